// File: rtl/mem_stage.sv
// MEM pipeline stage: 256 x 8 data memory with a two-state load FSM.
// A load takes two cycles. The first cycle stalls upstream and sends a bubble
// into MEM/WB while the byte is captured. The second cycle presents the load.
// Stores and ALU-only instructions pass straight through in one cycle.
module mem_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic       memRd_IN,
    input  logic       memWr_IN,
    input  logic       regWr_IN,
    input  logic [2:0] rd_IN,
    input  logic [7:0] aluRes_IN,
    input  logic [7:0] writeData_IN,
    output logic       memRd_OUT,
    output logic       regWr_OUT,
    output logic [2:0] rd_OUT,
    output logic [7:0] aluRes_OUT,
    output logic [7:0] memReadData_OUT,
    output logic       stall
);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] mem [0:255];
    logic [7:0] rdata_q;

    // State transitions, load-data capture, and memory write / reset clear
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rdata_q <= '0;
            for (int unsigned i = 0; i < 256; i++) begin
                mem[8'(i)] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // A load wins over a simultaneous store, so memory stays untouched
                    if (memRd_IN) begin
                        rdata_q <= mem[aluRes_IN];
                        state   <= LOAD;
                    end else if (memWr_IN) begin
                        mem[aluRes_IN] <= writeData_IN;
                    end
                end
                LOAD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output steering: same-cycle stall request, bubble insertion and pass-through
    always_comb begin
        stall           = 1'b0;
        memRd_OUT       = 1'b0;
        regWr_OUT       = 1'b0;
        rd_OUT          = '0;
        aluRes_OUT      = '0;
        memReadData_OUT = '0;
        if (!rst) begin
            rd_OUT     = rd_IN;
            aluRes_OUT = aluRes_IN;
            case (state)
                IDLE: begin
                    if (memRd_IN) begin
                        stall = 1'b1;
                    end else begin
                        memRd_OUT = memRd_IN;
                        regWr_OUT = regWr_IN;
                    end
                end
                LOAD: begin
                    memRd_OUT       = memRd_IN;
                    regWr_OUT       = regWr_IN;
                    memReadData_OUT = rdata_q;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_mem_stage;

    logic       clk;
    logic       rst;
    logic       memRd_IN;
    logic       memWr_IN;
    logic       regWr_IN;
    logic [2:0] rd_IN;
    logic [7:0] aluRes_IN;
    logic [7:0] writeData_IN;
    logic       memRd_OUT;
    logic       regWr_OUT;
    logic [2:0] rd_OUT;
    logic [7:0] aluRes_OUT;
    logic [7:0] memReadData_OUT;
    logic       stall;

    int checks = 0;
    int errors = 0;

    // Reference model: byte array plus "a load was issued last cycle" and its value
    logic [7:0] ref_mem [256];
    bit         load_pending;
    logic [7:0] load_val;

    // Outputs observed in the most recent cycle
    logic       o_stall, o_memRd, o_regWr;
    logic [2:0] o_rd;
    logic [7:0] o_alu, o_data;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .memRd_IN       (memRd_IN),
        .memWr_IN       (memWr_IN),
        .regWr_IN       (regWr_IN),
        .rd_IN          (rd_IN),
        .aluRes_IN      (aluRes_IN),
        .writeData_IN   (writeData_IN),
        .memRd_OUT      (memRd_OUT),
        .regWr_OUT      (regWr_OUT),
        .rd_OUT         (rd_OUT),
        .aluRes_OUT     (aluRes_OUT),
        .memReadData_OUT(memReadData_OUT),
        .stall          (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model
    task automatic cyc(input logic r, input logic mrd, input logic mwr, input logic rw,
                       input logic [2:0] rdi, input logic [7:0] alu, input logic [7:0] wd);
        @(negedge clk);
        rst = r; memRd_IN = mrd; memWr_IN = mwr; regWr_IN = rw;
        rd_IN = rdi; aluRes_IN = alu; writeData_IN = wd;
        #1;
        o_stall = stall; o_memRd = memRd_OUT; o_regWr = regWr_OUT;
        o_rd = rd_OUT; o_alu = aluRes_OUT; o_data = memReadData_OUT;
        if (r) begin
            chk("rst_stall", 8'(o_stall), 8'h00);
            chk("rst_memRd", 8'(o_memRd), 8'h00);
            chk("rst_regWr", 8'(o_regWr), 8'h00);
            chk("rst_rd",    8'(o_rd),    8'h00);
            chk("rst_alu",   o_alu,       8'h00);
            chk("rst_data",  o_data,      8'h00);
        end else if (load_pending) begin
            chk("ld_stall", 8'(o_stall), 8'h00);
            chk("ld_memRd", 8'(o_memRd), 8'(mrd));
            chk("ld_regWr", 8'(o_regWr), 8'(rw));
            chk("ld_rd",    8'(o_rd),    8'(rdi));
            chk("ld_alu",   o_alu,       alu);
            chk("ld_data",  o_data,      load_val);
        end else if (mrd) begin
            chk("bub_stall", 8'(o_stall), 8'h01);
            chk("bub_memRd", 8'(o_memRd), 8'h00);
            chk("bub_regWr", 8'(o_regWr), 8'h00);
        end else begin
            chk("pt_stall", 8'(o_stall), 8'h00);
            chk("pt_memRd", 8'(o_memRd), 8'h00);
            chk("pt_regWr", 8'(o_regWr), 8'(rw));
            chk("pt_rd",    8'(o_rd),    8'(rdi));
            chk("pt_alu",   o_alu,       alu);
            chk("pt_data",  o_data,      8'h00);
        end
        @(posedge clk);
        if (r) begin
            foreach (ref_mem[i]) ref_mem[i] = 8'h00;
            load_pending = 1'b0;
        end else if (load_pending) begin
            load_pending = 1'b0;
        end else if (mrd) begin
            load_val     = ref_mem[alu];
            load_pending = 1'b1;
        end else if (mwr) begin
            ref_mem[alu] = wd;
        end
    endtask

    initial begin
        logic       r_rst, r_rd, r_wr, r_rw;
        logic [2:0] r_rdi;
        logic [7:0] r_alu, r_wd;

        rst = 1'b1; memRd_IN = 1'b0; memWr_IN = 1'b0; regWr_IN = 1'b0;
        rd_IN = '0; aluRes_IN = '0; writeData_IN = '0;
        foreach (ref_mem[i]) ref_mem[i] = 8'h00;
        load_pending = 1'b0;
        load_val = 8'h00;

        // Reset state
        cyc(1, 0, 0, 0, 3'd0, 8'h00, 8'h00);
        cyc(1, 1, 1, 1, 3'd7, 8'hAA, 8'h55);

        // Load of 0x10 right after reset
        cyc(0, 1, 0, 1, 3'd5, 8'h10, 8'h00);
        chk("r21_c0_stall", 8'(o_stall), 8'h01);
        chk("r21_c0_regWr", 8'(o_regWr), 8'h00);
        cyc(0, 1, 0, 1, 3'd5, 8'h10, 8'h00);
        chk("r21_c1_stall", 8'(o_stall), 8'h00);
        chk("r21_c1_data",  o_data,      8'h00);
        chk("r21_c1_rd",    8'(o_rd),    8'h05);
        chk("r21_c1_regWr", 8'(o_regWr), 8'h01);

        // Store then immediate load of the same address
        cyc(0, 0, 1, 0, 3'd0, 8'h3C, 8'hA5);
        chk("r22_st_stall", 8'(o_stall), 8'h00);
        cyc(0, 1, 0, 1, 3'd1, 8'h3C, 8'h00);
        cyc(0, 1, 0, 1, 3'd1, 8'h3C, 8'h00);
        chk("r22_data", o_data, 8'hA5);

        // ALU-only pass-through
        cyc(0, 0, 0, 1, 3'd2, 8'h7F, 8'h00);
        chk("r23_stall", 8'(o_stall), 8'h00);
        chk("r23_alu",   o_alu,       8'h7F);
        chk("r23_regWr", 8'(o_regWr), 8'h01);
        chk("r23_rd",    8'(o_rd),    8'h02);
        chk("r23_data",  o_data,      8'h00);

        // Simultaneous load and store: load wins, memory unchanged
        cyc(0, 0, 1, 0, 3'd0, 8'h20, 8'h11);
        cyc(0, 1, 1, 1, 3'd3, 8'h20, 8'hFF);
        cyc(0, 1, 1, 1, 3'd3, 8'h20, 8'hFF);
        chk("r24_first", o_data, 8'h11);
        cyc(0, 1, 0, 1, 3'd3, 8'h20, 8'h00);
        cyc(0, 1, 0, 1, 3'd3, 8'h20, 8'h00);
        chk("r24_again", o_data, 8'h11);

        // Back-to-back loads including the top address
        cyc(0, 0, 1, 0, 3'd0, 8'h01, 8'h22);
        cyc(0, 0, 1, 0, 3'd0, 8'hFF, 8'h33);
        cyc(0, 1, 0, 1, 3'd4, 8'h01, 8'h00);
        chk("r25_s0", 8'(o_stall), 8'h01);
        cyc(0, 1, 0, 1, 3'd4, 8'h01, 8'h00);
        chk("r25_s1", 8'(o_stall), 8'h00);
        chk("r25_d0", o_data, 8'h22);
        cyc(0, 1, 0, 1, 3'd6, 8'hFF, 8'h00);
        chk("r25_s2", 8'(o_stall), 8'h01);
        cyc(0, 1, 0, 1, 3'd6, 8'hFF, 8'h00);
        chk("r25_s3", 8'(o_stall), 8'h00);
        chk("r25_d1", o_data, 8'h33);

        // Reset during LOAD abandons the load and clears memory
        cyc(0, 0, 1, 0, 3'd0, 8'h40, 8'h5A);
        cyc(0, 1, 0, 1, 3'd1, 8'h40, 8'h00);
        cyc(1, 1, 0, 1, 3'd1, 8'h40, 8'h00);
        cyc(0, 0, 0, 0, 3'd0, 8'h00, 8'h00);
        chk("r26_stall", 8'(o_stall), 8'h00);
        chk("r26_regWr", 8'(o_regWr), 8'h00);
        chk("r26_data",  o_data,      8'h00);
        cyc(0, 1, 0, 1, 3'd1, 8'h40, 8'h00);
        cyc(0, 1, 0, 1, 3'd1, 8'h40, 8'h00);
        chk("r26_cleared", o_data, 8'h00);

        // Random traffic; inputs are held for the second cycle of a load
        r_rst = 0; r_rd = 0; r_wr = 0; r_rw = 0; r_rdi = '0; r_alu = '0; r_wd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!load_pending) begin
                r_rst = ($urandom_range(0, 49) == 0);
                r_rd  = ($urandom_range(0, 2) == 0);
                r_wr  = ($urandom_range(0, 1) == 0);
                r_rw  = 1'($urandom_range(0, 1));
                r_rdi = 3'($urandom_range(0, 7));
                r_alu = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                    : 8'($urandom_range(0, 15));
                r_wd  = 8'($urandom_range(0, 255));
            end else begin
                r_rst = 1'b0;
            end
            cyc(r_rst, r_rd, r_wr, r_rw, r_rdi, r_alu, r_wd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have a single clock domain with one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- memRd_IN  in  1  instruction in the stage is a load.
- memWr_IN  in  1  instruction in the stage is a store.
- regWr_IN  in  1  instruction writes the register file.
- rd_IN  in  3  destination register index.
- aluRes_IN  in  8  ALU result; used as the byte address for a load or store.
- writeData_IN  in  8  store data.
- memRd_OUT  out  1  load flag toward the MEM/WB register.
- regWr_OUT  out  1  register write enable toward the MEM/WB register.
- rd_OUT  out  3  destination index toward the MEM/WB register.
- aluRes_OUT  out  8  ALU result toward the MEM/WB register.
- memReadData_OUT  out  8  loaded byte toward the MEM/WB register.
- stall  out  1  freeze request to the PC and the IF/ID and ID/EX/EX-MEM registers.

Function
REQ-003 The block SHALL contain a 256 x 8 data memory, addressed by aluRes_IN[7:0].
REQ-004 The FSM SHALL have two states, IDLE and LOAD, and SHALL enter IDLE on reset.
REQ-005 In IDLE with memRd_IN=1, the block SHALL do all of the following:
- Assert stall=1 combinationally.
- Drive memRd_OUT=0 and regWr_OUT=0 (a bubble into MEM/WB).
- At the clock edge, register mem[aluRes_IN] into rdata_q and move to LOAD.
REQ-006 In LOAD, the block SHALL do all of the following:
- Drive stall=0.
- Drive memRd_OUT=memRd_IN, regWr_OUT=regWr_IN, rd_OUT=rd_IN, aluRes_OUT=aluRes_IN and memReadData_OUT=rdata_q.
- Return to IDLE at the next edge unconditionally.
REQ-007 Each load SHALL therefore cost exactly 2 cycles, and a load SHALL be presented to MEM/WB exactly one cycle after it first appears at the inputs.
REQ-008 Upstream SHALL hold every input stable while stall=1; the block SHALL use the inputs it sees in LOAD as the load's control fields.
REQ-009 In IDLE with memRd_IN=0 and memWr_IN=1, the block SHALL write writeData_IN into mem[aluRes_IN] at the clock edge.
REQ-010 A store SHALL take 1 cycle, SHALL keep stall=0, and SHALL pass regWr_IN and rd_IN through unchanged.
REQ-011 In IDLE with memRd_IN=0, the block SHALL drive:
- stall=0
- memReadData_OUT=8'h00
- all other outputs equal to their corresponding inputs.
REQ-012 If memRd_IN=1 and memWr_IN=1 arrive together, the load SHALL take priority and the memory SHALL NOT be written in either cycle.
REQ-013 memWr_IN SHALL be ignored in LOAD.
REQ-014 A store followed in the next cycle by a load from the same address SHALL return the newly stored byte.
REQ-015 Back-to-back loads SHALL each stall for one cycle; the FSM SHALL revisit IDLE between them.
REQ-016 Address wrap-around SHALL NOT exist, since the 8-bit address covers the full memory.

Reset
REQ-017 While rst=1, all outputs SHALL be 0, including stall.
REQ-018 At a clock edge with rst=1, the block SHALL do all of the following:
- Force state IDLE.
- Clear rdata_q to 0.
- Clear all 256 memory bytes to 8'h00.
REQ-019 A reset asserted while in LOAD SHALL abandon the load, with no output and stall=0 in the next cycle.
REQ-020 The first cycle after rst deasserts SHALL behave as IDLE.

Verification
REQ-021 Reset, then a load of address 8'h10 with rd_IN=3'd5, regWr_IN=1 -> the bench SHALL observe:
- Cycle 0: stall=1, regWr_OUT=0.
- Cycle 1: stall=0, memReadData_OUT=8'h00, rd_OUT=5, regWr_OUT=1.
REQ-022 Store 8'hA5 to address 8'h3C, then load 8'h3C in the next cycle -> the LOAD cycle SHALL give memReadData_OUT=8'hA5.
REQ-023 ALU op with aluRes_IN=8'h7F, regWr_IN=1, rd_IN=2 -> in the same cycle: stall=0, aluRes_OUT=8'h7F, regWr_OUT=1, rd_OUT=2, memReadData_OUT=0.
REQ-024 memRd_IN=1 and memWr_IN=1 with writeData_IN=8'hFF at address 8'h20 (prior content 8'h11) -> load returns 8'h11, and a later load of 8'h20 also returns 8'h11.
REQ-025 Two consecutive loads from 8'h01 (content 8'h22) and 8'hFF (content 8'h33) -> stall pattern 1,0,1,0; results 8'h22 then 8'h33.
REQ-026 rst=1 during LOAD -> in the next cycle, stall=0 and all outputs are 0; a previously stored byte reads back as 8'h00.
